vga_adapter: RTL and testbench



---
 rtl/vga_adapter.sv | 114 +++++++++++
 tb/tb_vga_adapter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vga_adapter.sv
// VGA scan-out adapter: pixel-addressed frame buffer plus 640x480@60 raster
// timing for the DE1-SoC video DAC. Clients write one 9-bit colour per clock.
// The scan-out runs at clock/2 and produces RGB, sync, blank and pixel clock.
module vga_adapter #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int COLOR_BITS = 9,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [COLOR_BITS-1:0] color,
  input  logic [9:0]            x,
  input  logic [8:0]            y,
  input  logic                  write,
  output logic [7:0]            VGA_R,
  output logic [7:0]            VGA_G,
  output logic [7:0]            VGA_B,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic                  VGA_BLANK_N,
  output logic                  VGA_SYNC_N,
  output logic                  VGA_CLK
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int NPIX    = H_RES * V_RES;
  localparam int AW      = $clog2(NPIX);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [COLOR_BITS-1:0] mem [0:NPIX-1];
  logic [COLOR_BITS-1:0] rd_data;
  logic [AW-1:0]         wr_addr, rd_addr;
  logic                  wr_ok;
  logic                  pe;
  logic [HW-1:0]         hcnt;
  logic [VW-1:0]         vcnt;
  logic                  visible, hs_act, vs_act;

  // 3-bit channel to 8-bit DAC code by bit replication (000->00, 111->FF)
  function automatic logic [7:0] expand(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  // Background at power-up is black; the buffer is never touched by reset.
  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = '0;
  end

  // Writes outside the visible area (including wrapped negatives) are dropped.
  assign wr_ok   = write && (int'(x) < H_RES) && (int'(y) < V_RES);
  assign wr_addr = AW'(int'(y) * H_RES + int'(x));

  assign visible = (int'(hcnt) < H_RES) && (int'(vcnt) < V_RES);
  assign hs_act  = (int'(hcnt) >= H_RES + H_FP) && (int'(hcnt) < H_RES + H_FP + H_SYNC);
  assign vs_act  = (int'(vcnt) >= V_RES + V_FP) && (int'(vcnt) < V_RES + V_FP + V_SYNC);
  assign rd_addr = visible ? AW'(int'(vcnt) * H_RES + int'(hcnt)) : '0;

  // Client write port: always ready, one pixel per clock
  always @(posedge clock) begin
    if (wr_ok) mem[wr_addr] <= color;
  end

  // Scan-out read port; the address is stable for both clocks of a pixel, so
  // the data is ready by the pixel edge that consumes it.
  always_ff @(posedge clock) begin
    rd_data <= mem[rd_addr];
  end

  // Pixel tick, raster counters and registered DAC outputs. Sync/blank are
  // registered on the same edge as RGB so all outputs for (h,v) leave together.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pe          <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      pe <= ~pe;
      if (pe) begin
        if (int'(hcnt) == H_TOTAL - 1) begin
          hcnt <= '0;
          if (int'(vcnt) == V_TOTAL - 1) vcnt <= '0;
          else                           vcnt <= vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
        VGA_HS      <= ~hs_act;
        VGA_VS      <= ~vs_act;
        VGA_BLANK_N <= visible;
        VGA_R       <= visible ? expand(rd_data[8:6]) : 8'h00;
        VGA_G       <= visible ? expand(rd_data[5:3]) : 8'h00;
        VGA_B       <= visible ? expand(rd_data[2:0]) : 8'h00;
      end
    end
  end

  assign VGA_CLK    = pe;
  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_adapter.sv
// Scoreboard bench for vga_adapter on a reduced raster (32x24 visible,
// 48x31 total). The driver pushes one expected record per pixel period for a
// whole frame; the monitor pops one record each time the DUT emits a pixel.
module tb_vga_adapter;

  localparam int HT = 48, VT = 31, F = HT * VT;

  logic       clock, resetn, write;
  logic [8:0] color;
  logic [9:0] x;
  logic [8:0] y;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;

  vga_adapter #(
    .H_RES(32), .V_RES(24), .COLOR_BITS(9),
    .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clock(clock), .resetn(resetn), .color(color), .x(x), .y(y), .write(write),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK)
  );

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs, vs, bn, dc;
    logic [5:0]  h;
    logic [4:0]  v;
  } exp_t;

  exp_t       q[$];
  logic [8:0] sh [0:767];
  int         checks = 0, errors = 0, pops = 0, ecnt = 0;
  bit         mon_on = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // clocks since reset release, used to locate pixel edges independently of the DUT
  always @(posedge clock) begin
    if (!resetn) ecnt <= 0;
    else         ecnt <= ecnt + 1;
  end

  // hand-tabulated DAC codes for each 3-bit level
  function automatic logic [7:0] lvl(input logic [2:0] c);
    case (c)
      3'd0: return 8'h00;  3'd1: return 8'h24;
      3'd2: return 8'h49;  3'd3: return 8'h6D;
      3'd4: return 8'h92;  3'd5: return 8'hB6;
      3'd6: return 8'hDB;  default: return 8'hFF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic rst_chk();
    chk("rst_hs", 32'(VGA_HS), 32'd1);
    chk("rst_vs", 32'(VGA_VS), 32'd1);
    chk("rst_blank_n", 32'(VGA_BLANK_N), 32'd0);
    chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    chk("rst_clk", 32'(VGA_CLK), 32'd0);
    chk("rst_sync_n", 32'(VGA_SYNC_N), 32'd0);
  endtask

  // Expected frame: hsync low on h 36..43, vsync low on v 26..27, visible h<32 && v<24.
  // dc_box marks the burst region as don't-care for the frame the burst overlaps.
  task automatic push_frame(input bit dc_box);
    exp_t e;
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++) begin
        e.h   = 6'(h);
        e.v   = 5'(v);
        e.bn  = (h < 32) && (v < 24);
        e.hs  = !(h >= 36 && h <= 43);
        e.vs  = !(v == 26 || v == 27);
        e.dc  = dc_box && h < 16 && v >= 8 && v < 24;
        e.rgb = e.bn ? {lvl(sh[v*32+h][8:6]), lvl(sh[v*32+h][5:3]), lvl(sh[v*32+h][2:0])} : 24'h0;
        q.push_back(e);
      end
  endtask

  task automatic wr(input logic [9:0] wx, input logic [8:0] wy, input logic [8:0] c);
    x = wx; y = wy; color = c; write = 1'b1;
    if (wx < 32 && wy < 24) sh[wy*32+wx] = c;
    @(posedge clock); #2;
    write = 1'b0;
  endtask

  task automatic wait_pops(input int n);
    int t = 0;
    while (pops < n && t < 8000) begin
      @(posedge clock); #2;
      t++;
    end
    if (pops < n) begin
      checks++; errors++;
      $display("FAIL wait_pops timeout pops=%0d need=%0d", pops, n);
    end
  endtask

  // Monitor: odd clocks since release must show VGA_CLK=1; every even clock is a
  // new pixel, compared against the next scoreboard entry.
  always @(negedge clock) begin
    exp_t e;
    logic [23:0] got;
    if (mon_on && resetn && ecnt >= 1) begin
      checks++;
      if (VGA_CLK !== ecnt[0] || VGA_SYNC_N !== 1'b0) begin
        errors++;
        $display("FAIL pixclk ecnt=%0d got clk=%b sync_n=%b exp clk=%b sync_n=0", ecnt, VGA_CLK, VGA_SYNC_N, ecnt[0]);
      end
      if (!ecnt[0]) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard underflow at ecnt=%0d", ecnt);
        end else begin
          e   = q.pop_front();
          pops++;
          got = {VGA_R, VGA_G, VGA_B};
          if (VGA_HS !== e.hs || VGA_VS !== e.vs || VGA_BLANK_N !== e.bn || (!e.dc && got !== e.rgb)) begin
            errors++;
            $display("FAIL pix h=%0d v=%0d got rgb=%h hs=%b vs=%b bn=%b exp rgb=%h hs=%b vs=%b bn=%b",
                     e.h, e.v, got, VGA_HS, VGA_VS, VGA_BLANK_N, e.rgb, e.hs, e.vs, e.bn);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 768; i++) sh[i] = '0;
    resetn = 1'b0; write = 1'b0; x = '0; y = '0; color = '0;
    repeat (3) @(posedge clock);
    #2;
    rst_chk();

    // frame 0: blank background, full timing
    push_frame(1'b0);
    pops = 0; resetn = 1'b1; mon_on = 1'b1;

    // vertical blank of frame 0: single pixels and rejected coordinates
    wait_pops(24 * HT + 1);
    wr(10'd16, 9'd12, 9'h1FF);
    wr(10'd0,  9'd0,  9'b100_010_001);
    wr(10'd31, 9'd23, 9'b100_010_001);
    wr(10'd700, 9'd5, 9'h1FF);
    wr(10'd5, 9'd500, 9'h1FF);
    wr(10'h3F0, 9'd3, 9'h1FF);
    wr(10'd32, 9'd0,  9'h1FF);
    wr(10'd40, 9'd2,  9'h1FF);
    wr(10'd0,  9'd24, 9'h1FF);
    push_frame(1'b1);

    // frame 1: 16x16 burst at one pixel per clock while scanning
    wait_pops(F + 1);
    for (int yy = 8; yy < 24; yy++)
      for (int xx = 0; xx < 16; xx++)
        wr(10'(xx), 9'(yy), 9'b011_101_110);

    // frame 2 must show the complete box
    wait_pops(F + 24 * HT + 1);
    push_frame(1'b0);

    // mid-line reset in frame 2, then a full frame from (0,0) with retained contents
    wait_pops(2 * F + 5 * HT + 10);
    resetn = 1'b0; mon_on = 1'b0; q.delete();
    repeat (3) @(posedge clock);
    #2;
    rst_chk();
    push_frame(1'b0);
    pops = 0; resetn = 1'b1; mon_on = 1'b1;
    wait_pops(F);
    mon_on = 1'b0;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
